// File: rtl/processador_pio_in_edge.sv
// Parametrised input PIO with a synchroniser, per-bit edge capture (RW1C), an interrupt mask
// and a level IRQ, on an Avalon-MM slave with 1-cycle registered read data.
`timescale 1ns/1ps
module processador_pio_in_edge #(
  parameter int                     WIDTH       = 8,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0]       RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  localparam int              WARM_MAX  = SYNC_STAGES + 1;
  localparam int              WARM_W    = $clog2(WARM_MAX + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_MAX);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WARM_W-1:0]                 r_warm;
  logic [WIDTH-1:0]                  r_edge_capture;
  logic [WIDTH-1:0]                  r_irq_mask;

  logic [WIDTH-1:0] w_sync_q;
  logic             w_armed;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic             w_wr;
  logic             w_wr_mask;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_mux;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  // Edges stay disarmed until the synchroniser and prev hold real samples.
  assign w_armed  = (r_warm == WARM_DONE);

  assign w_wr      = chipselect & write;
  assign w_wr_mask = w_wr && (address == ADDR_MASK);
  assign w_w1c     = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_rise = w_sync_q & ~r_prev;
    w_fall = ~w_sync_q & r_prev;
    w_edge = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        0:       w_edge = w_rise;
        1:       w_edge = w_fall;
        default: w_edge = w_rise | w_fall;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(w_sync_q);
      ADDR_RSVD: w_rd_mux = '0;
      ADDR_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge_capture);
      default:   w_rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_q;
      if (!w_armed) r_warm <= r_warm + 1'b1;
    end
  end

  // Set wins over a same-cycle W1C so an edge arriving during a clear is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_capture <= '0;
      r_irq_mask     <= RESET_MASK;
      readdata       <= '0;
    end else begin
      r_edge_capture <= (r_edge_capture & ~w_w1c) | w_edge;
      if (w_wr_mask) r_irq_mask <= writedata[WIDTH-1:0];
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_capture & r_irq_mask);

  if (WIDTH < 32) begin : g_upper
    logic w_unused;
    assign w_unused = &{1'b0, writedata[31:WIDTH]};
  end

endmodule
